// File: rtl/hash_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks of the hashing datapath.
package hash_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ser_state_e;

  localparam int SLICE_W_DEF = 8;

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice: {bout, diff} = a - b - bin.
module sub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] diff_o,
  output logic         bout_o
);

  // W+1-bit result: the top bit is set exactly when a < b + bin.
  logic [W:0] res;
  assign res    = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
  assign diff_o = res[W-1:0];
  assign bout_o = res[W];

endmodule

// File: rtl/sub32_serial.sv
// Serial WIDTH-bit subtractor, one SLICE_W slice per clock, LSB first, with a
// start/busy/done handshake. d/bo update only when entering DONE.
module sub32_serial
  import hash_arith_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

  ser_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic [NSLICE-1:0][SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W-1:0]             sl_diff;
  logic                           sl_bo;

  assign a_sl = a_q;
  assign b_sl = b_q;

  sub_slice #(.W(SLICE_W)) u_slice (
    .a_i    (a_sl[idx_q]),
    .b_i    (b_sl[idx_q]),
    .bin_i  (br_q),
    .diff_o (sl_diff),
    .bout_o (sl_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      acc_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bo_d    = bo_q;
    case (state_q)
      // DONE accepts a new start like IDLE so back-to-back ops need no gap.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bi;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        br_d  = sl_bo;
        acc_d = {sl_diff, acc_q[WIDTH-1:SLICE_W]};
        if (idx_q == LAST) begin
          d_d     = {sl_diff, acc_q[WIDTH-1:SLICE_W]};
          bo_d    = sl_bo;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Directed self-checking bench for sub32_serial.
module tb_sub32_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        bi = 1'b0;
  logic        busy, done, bo;
  logic [31:0] d;

  int errs = 0;
  int checks = 0;

  sub32_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy), .done(done), .d(d), .bo(bo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] av, input logic [31:0] bv, input logic biv);
    a = av; b = bv; bi = biv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom);
  endtask

  // Called right after the accepting edge; expects done 4 edges later.
  task automatic wait_done(input string tag, input logic [31:0] ed, input logic ebo,
                           input bit leave_in_done);
    int n = 0;
    int nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({tag, ".lat"}, n, 4);
    check({tag, ".busycyc"}, nb, 4);
    check({tag, ".busy_in_done"}, busy, 0);
    check({tag, ".d"}, d, ed);
    check({tag, ".bo"}, bo, ebo);
    if (!leave_in_done) begin
      tick();
      check({tag, ".pulse"}, done, 0);
      check({tag, ".hold_d"}, d, ed);
    end
  endtask

  initial begin
    int nd;
    #2;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.d", d, 0);
    check("rst.bo", bo, 0);
    tick();
    rst_n = 1'b1;
    tick();

    do_start(32'h5, 32'h3, 1'b0);
    wait_done("t1", 32'h2, 1'b0, 0);

    do_start(32'h0, 32'h1, 1'b0);
    wait_done("t2", 32'hFFFF_FFFF, 1'b1, 0);

    do_start(32'h0001_0000, 32'h1, 1'b0);
    wait_done("t3a", 32'h0000_FFFF, 1'b0, 0);

    do_start(32'h10, 32'h0F, 1'b1);
    wait_done("t3b", 32'h0, 1'b0, 0);

    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("t_all1", 32'hFFFF_FFFF, 1'b1, 0);

    do_start(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_done("t_msb", 32'h1, 1'b0, 0);

    // Start while busy must be ignored.
    do_start(32'h10, 32'h01, 1'b0);
    tick();
    a = 32'hFF; b = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 2; i++) begin
      if (done) nd++;
      tick();
    end
    check("t4.done_now", done, 1);
    check("t4.early_done", nd, 0);
    check("t4.d", d, 32'h0F);
    // Start in the done cycle is accepted at once.
    a = 32'h20; b = 32'h10; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4.b2b_busy", busy, 1);
    wait_done("t4b", 32'h10, 1'b0, 0);

    // Reset in the middle of RUN.
    do_start(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5.rst_busy", busy, 0);
    check("t5.rst_done", done, 0);
    check("t5.rst_d", d, 0);
    check("t5.rst_bo", bo, 0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) nd++;
      tick();
    end
    check("t5.no_done", nd, 0);
    check("t5.d_after", d, 0);
    do_start(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("t5b", 32'h0123_4567, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sub32_serial.md
Name: sub32_serial

Overview:
- Multi-cycle 32-bit subtractor for the hashing datapath. Computes d = a − b − bi one 8-bit slice per clock, LSB slice first, rippling a registered borrow between slices.
- Complements the combinational slice-based adders: used where a difference or an un-add (state rollback, message-schedule check) is needed and area matters more than latency.
- Start/busy/done handshake toward the hash control FSM.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE_W.
- SLICE_W, 8, bits processed per cycle.
- NSLICE, WIDTH/SLICE_W (derived localparam, 4), cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- bi  input  1  borrow in; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- d  output  WIDTH  difference, held until the next completion.
- bo  output  1  borrow out of MSB slice, held with d.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, d=0, bo=0, slice index=0, internal borrow=0, operand registers=0.
- States:
  - IDLE: start=1 at edge E0 latches a, b, bi, then goes to RUN with idx=0.
  - RUN: at each edge, slice idx computes {borrow, diff} = a_slice − b_slice − borrow and writes diff into the result shift/accumulate register. On idx=NSLICE−1, go to DONE; otherwise idx+1.
  - DONE: for exactly one cycle, done=1 and busy=0, then return to IDLE.
- Output update: d and bo are written only on the edge entering DONE, never slice by slice.
- Latency: start accepted at E0; the last slice completes at E0+NSLICE (E4); done is high in the cycle following E4.
- busy=1 in the cycles after E0..E3 (exactly NSLICE cycles).
- start while busy: ignored; the latched operands are unaffected.
- start while done=1: treated as IDLE-equivalent. It is accepted at that edge and goes straight to RUN, so back-to-back operations need no idle gap. Throughput is one result per NSLICE+1 cycles.
- Arithmetic:
  - Modular 2^WIDTH.
  - Per-slice borrow = 1 when a_slice < b_slice + borrow_in (unsigned, SLICE_W+1-bit compare).
  - bo = 1 exactly when {a} < {b} + bi as unsigned WIDTH-bit values.
- Operands a, b, bi may change freely after acceptance.
- Reset mid-RUN: abort immediately, no done pulse, d/bo return to 0.

Decomposition:
- Shared package, hash_arith_pkg: the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the SLICE_W default constant, shared with future serial arithmetic blocks.
- One natural sub-module, sub_slice: combinational SLICE_W-bit subtract with borrow in and borrow out, the dual of the 8-bit adder slice.
- sub32_serial instantiates one sub_slice and muxes operand bytes by idx.

Test Plan:
- a=0x00000005, b=0x00000003, bi=0 -> busy for 4 cycles; done pulse in cycle 5 after start; d=0x00000002, bo=0.
- a=0x00000000, b=0x00000001, bi=0 -> d=0xFFFFFFFF, bo=1; confirms borrow ripples through all 4 slices.
- a=0x00010000, b=0x00000001 -> d=0x0000FFFF, bo=0. Then a=0x00000010, b=0x0000000F, bi=1 -> d=0x00000000, bo=0.
- start with a=0x10, b=0x01; pulse start again at cycle 2 with a=0xFF, b=0x00 -> second start ignored; d=0x0000000F with a single done pulse. Then assert start in the done cycle with a=0x20, b=0x10 -> next done exactly 5 cycles later, d=0x00000010.
- Start a=0x12345678, b=0x11111111; drop rst_n for 1 cycle at idx=2 -> no done; busy=0, d=0x00000000, bo=0. A new start completes normally with d=0x01234567.
